// File: rtl/mips_regfile_bist_pkg.sv
// Shared types and data-pattern helpers for the MIPS register-file BIST.
// Expected read data accounts for r0 being hardwired to zero.
package mips_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE_A,
    READ_A,
    WRITE_B,
    READ_B,
    DONE_PASS,
    DONE_FAIL
  } bist_state_t;

  localparam logic [31:0] DEFAULT_PATTERN_A = 32'hAAAAAAAA;
  localparam logic [31:0] DEFAULT_PATTERN_B = 32'h55555555;

  // Mixing the register number into the pattern makes address aliasing visible.
  function automatic logic [31:0] pattern_word(input logic [31:0] pattern,
                                               input logic [4:0]  regnum);
    return pattern ^ {27'b0, regnum};
  endfunction

  function automatic logic [31:0] expected_word(input logic [31:0] pattern,
                                                input logic [4:0]  regnum);
    return (regnum == 5'd0) ? 32'd0 : pattern_word(pattern, regnum);
  endfunction

endpackage

// File: rtl/mips_regfile_bist_cmp.sv
// Dual read-port compare against the expected pattern; rd1 wins when both
// ports disagree so the reported failure is deterministic.
module mips_regfile_bist_cmp
  import mips_bist_pkg::*;
(
  input  logic [31:0] pattern,
  input  logic [4:0]  rd1_regnum,
  input  logic [4:0]  rd2_regnum,
  input  logic [31:0] rd1_data,
  input  logic [31:0] rd2_data,
  output logic        mismatch,
  output logic        sel_port,
  output logic [4:0]  sel_regnum,
  output logic [31:0] sel_data
);

  logic rd1_bad;
  logic rd2_bad;

  assign rd1_bad  = (rd1_data != expected_word(pattern, rd1_regnum));
  assign rd2_bad  = (rd2_data != expected_word(pattern, rd2_regnum));
  assign mismatch = rd1_bad | rd2_bad;

  always_comb begin
    sel_port   = 1'b0;
    sel_regnum = rd1_regnum;
    sel_data   = rd1_data;
    if (!rd1_bad && rd2_bad) begin
      sel_port   = 1'b1;
      sel_regnum = rd2_regnum;
      sel_data   = rd2_data;
    end
  end

endmodule

// File: rtl/mips_regfile_bist.sv
// Register-file BIST: write/read-back with two complementary patterns,
// stopping at the first mismatch and latching where it occurred.
module mips_regfile_bist
  import mips_bist_pkg::*;
#(
  parameter int          NUM_REGS  = 32,
  parameter logic [31:0] PATTERN_A = DEFAULT_PATTERN_A,
  parameter logic [31:0] PATTERN_B = DEFAULT_PATTERN_B
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  rf_wr_regnum,
  output logic [31:0] rf_wr_data,
  output logic        rf_wr_enable,
  output logic [4:0]  rf_rd1_regnum,
  output logic [4:0]  rf_rd2_regnum,
  input  logic [31:0] rf_rd1_data,
  input  logic [31:0] rf_rd2_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail_port,
  output logic [4:0]  fail_regnum,
  output logic [31:0] fail_data
);

  localparam logic [4:0] LAST = 5'(NUM_REGS - 1);

  bist_state_t state, state_next;
  logic [4:0]  i;
  logic [31:0] cmp_pattern;
  logic        mismatch;
  logic        sel_port;
  logic [4:0]  sel_regnum;
  logic [31:0] sel_data;
  logic        load_fail;
  logic        restart;

  assign cmp_pattern = (state == READ_B) ? PATTERN_B : PATTERN_A;

  mips_regfile_bist_cmp u_cmp (
    .pattern    (cmp_pattern),
    .rd1_regnum (rf_rd1_regnum),
    .rd2_regnum (rf_rd2_regnum),
    .rd1_data   (rf_rd1_data),
    .rd2_data   (rf_rd2_data),
    .mismatch   (mismatch),
    .sel_port   (sel_port),
    .sel_regnum (sel_regnum),
    .sel_data   (sel_data)
  );

  always_comb begin
    state_next    = state;
    rf_wr_enable  = 1'b0;
    rf_wr_regnum  = 5'd0;
    rf_wr_data    = 32'd0;
    rf_rd1_regnum = 5'd0;
    rf_rd2_regnum = 5'd0;
    busy          = 1'b0;
    done          = 1'b0;
    pass          = 1'b0;
    load_fail     = 1'b0;
    restart       = 1'b0;
    case (state)
      IDLE, DONE_PASS, DONE_FAIL: begin
        done = (state != IDLE);
        pass = (state == DONE_PASS);
        if (start) begin
          state_next = WRITE_A;
          restart    = 1'b1;
        end
      end
      WRITE_A, WRITE_B: begin
        busy         = 1'b1;
        rf_wr_enable = 1'b1;
        rf_wr_regnum = i;
        rf_wr_data   = pattern_word((state == WRITE_A) ? PATTERN_A : PATTERN_B, i);
        if (i == LAST) state_next = (state == WRITE_A) ? READ_A : READ_B;
      end
      READ_A, READ_B: begin
        busy          = 1'b1;
        rf_rd1_regnum = i;
        rf_rd2_regnum = LAST - i;
        if (mismatch) begin
          state_next = DONE_FAIL;
          load_fail  = 1'b1;
        end else if (i == LAST) begin
          state_next = (state == READ_A) ? WRITE_B : DONE_PASS;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Failure record is reset too: all outputs must read zero after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      i           <= 5'd0;
      fail_port   <= 1'b0;
      fail_regnum <= 5'd0;
      fail_data   <= 32'd0;
    end else begin
      state <= state_next;
      // Phase changes coincide with i == LAST, so any state change wraps i.
      if (busy && state_next == state) i <= i + 5'd1;
      else                             i <= 5'd0;
      if (load_fail) begin
        fail_port   <= sel_port;
        fail_regnum <= sel_regnum;
        fail_data   <= sel_data;
      end else if (restart) begin
        fail_port   <= 1'b0;
        fail_regnum <= 5'd0;
        fail_data   <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mips_regfile_bist.sv
// Bench for mips_regfile_bist: faulty/good regfile model, run-level reference
// model compared every cycle, plus directed literal checks on each scenario.
module tb_mips_regfile_bist;

  localparam int          NR = 32;
  localparam logic [31:0] PA = 32'hAAAAAAAA;
  localparam logic [31:0] PB = 32'h55555555;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  rf_wr_regnum;
  logic [31:0] rf_wr_data;
  logic        rf_wr_enable;
  logic [4:0]  rf_rd1_regnum;
  logic [4:0]  rf_rd2_regnum;
  logic [31:0] rf_rd1_data;
  logic [31:0] rf_rd2_data;
  logic        busy, done, pass, fail_port;
  logic [4:0]  fail_regnum;
  logic [31:0] fail_data;

  int checks = 0;
  int errors = 0;
  // 0 good, 1 reg5 bit3 stuck-at-0, 2 writable r0, 3 write to r17 aliases r1
  int mode = 0;
  logic [31:0] regs [NR];

  mips_regfile_bist dut (
    .clk(clk), .reset(reset), .start(start),
    .rf_wr_regnum(rf_wr_regnum), .rf_wr_data(rf_wr_data), .rf_wr_enable(rf_wr_enable),
    .rf_rd1_regnum(rf_rd1_regnum), .rf_rd2_regnum(rf_rd2_regnum),
    .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
    .busy(busy), .done(done), .pass(pass), .fail_port(fail_port),
    .fail_regnum(fail_regnum), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  initial for (int r = 0; r < NR; r++) regs[r] = 32'd0;

  always @(posedge clk) begin
    if (rf_wr_enable) begin
      regs[rf_wr_regnum] <= rf_wr_data;
      if (mode == 3 && rf_wr_regnum == 5'd17) regs[1] <= rf_wr_data;
    end
  end

  function automatic logic [31:0] rf_read(input int r);
    logic [31:0] d;
    d = regs[r];
    if (r == 0 && mode != 2) d = 32'd0;
    if (mode == 1 && r == 5) d[3] = 1'b0;
    return d;
  endfunction

  always_comb begin
    rf_rd1_data = regs[rf_rd1_regnum];
    if (rf_rd1_regnum == 5'd0 && mode != 2) rf_rd1_data = 32'd0;
    if (mode == 1 && rf_rd1_regnum == 5'd5) rf_rd1_data[3] = 1'b0;
  end

  always_comb begin
    rf_rd2_data = regs[rf_rd2_regnum];
    if (rf_rd2_regnum == 5'd0 && mode != 2) rf_rd2_data = 32'd0;
    if (mode == 1 && rf_rd2_regnum == 5'd5) rf_rd2_data[3] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run = 4*NR cycles; cycle k is phase k/NR, index k%NR.
  int          m_st = 0;  // 0 idle, 1 running, 2 done pass, 3 done fail
  int          m_k  = 0;
  logic        m_fport = 1'b0;
  logic [31:0] m_freg  = 32'd0;
  logic [31:0] m_fdata = 32'd0;
  bit          armed   = 1'b0;

  function automatic logic [31:0] want(input logic [31:0] pat, input int r);
    return (r == 0) ? 32'd0 : (pat ^ 32'(r));
  endfunction

  always @(negedge clk) begin
    int phase, idx, r2;
    logic [31:0] pat;
    bit wr, rd;
    phase = m_k / NR;
    idx   = m_k % NR;
    r2    = NR - 1 - idx;
    pat   = (phase < 2) ? PA : PB;
    wr    = (m_st == 1) && (phase % 2 == 0);
    rd    = (m_st == 1) && (phase % 2 == 1);
    if (armed) begin
      chk("busy",        32'(busy),          32'(m_st == 1));
      chk("done",        32'(done),          32'(m_st >= 2));
      chk("pass",        32'(pass),          32'(m_st == 2));
      chk("wr_enable",   32'(rf_wr_enable),  32'(wr));
      chk("wr_regnum",   32'(rf_wr_regnum),  wr ? 32'(idx) : 32'd0);
      chk("wr_data",     rf_wr_data,         wr ? (pat ^ 32'(idx)) : 32'd0);
      chk("rd1_regnum",  32'(rf_rd1_regnum), rd ? 32'(idx) : 32'd0);
      chk("rd2_regnum",  32'(rf_rd2_regnum), rd ? 32'(r2) : 32'd0);
      chk("fail_port",   32'(fail_port),     32'(m_fport));
      chk("fail_regnum", 32'(fail_regnum),   m_freg);
      chk("fail_data",   fail_data,          m_fdata);
    end
    if (!reset) begin
      m_st = 0; m_k = 0; m_fport = 0; m_freg = 0; m_fdata = 0;
      armed = 1'b1;
    end else if (m_st != 1) begin
      if (start) begin
        m_st = 1; m_k = 0; m_fport = 0; m_freg = 0; m_fdata = 0;
      end
    end else begin
      if (rd && rf_read(idx) != want(pat, idx)) begin
        m_st = 3; m_fport = 0; m_freg = 32'(idx); m_fdata = rf_read(idx);
      end else if (rd && rf_read(r2) != want(pat, r2)) begin
        m_st = 3; m_fport = 1; m_freg = 32'(r2); m_fdata = rf_read(r2);
      end else begin
        m_k++;
        if (m_k == 4 * NR) m_st = 2;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Counts busy cycles from the current one; optionally re-pulses start mid-run.
  task automatic count_busy(input int pulse_at, output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      if (n == pulse_at) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n++;
    end
    if (n >= 1000) chk("busy_timeout", 32'(n), 32'd0);
  endtask

  task automatic fault_run(input int m, input int exp_len, input logic [31:0] exp_reg,
                           input logic [31:0] exp_data);
    int n;
    mode = m;
    pulse_start();
    count_busy(-1, n);
    chk("fault_len",    32'(n),           32'(exp_len));
    chk("fault_done",   32'(done),        32'd1);
    chk("fault_pass",   32'(pass),        32'd0);
    chk("fault_regnum", 32'(fail_regnum), exp_reg);
    chk("fault_data",   fail_data,        exp_data);
    chk("fault_port",   32'(fail_port),   32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_done",  32'(done),         32'd0);
    chk("rst_wr_en", 32'(rf_wr_enable), 32'd0);
    start = 1'b0;
    reset = 1'b1;

    // Good run with a start re-pulse while busy
    pulse_start();
    count_busy(20, n);
    chk("pass_len",    32'(n),           32'd128);
    chk("pass_done",   32'(done),        32'd1);
    chk("pass_pass",   32'(pass),        32'd1);
    chk("pass_regnum", 32'(fail_regnum), 32'd0);

    // Restart from DONE_PASS
    pulse_start();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    count_busy(-1, n);
    chk("restart_len",  32'(n),    32'd128);
    chk("restart_pass", 32'(pass), 32'd1);

    fault_run(1, 38, 32'd5, 32'hAAAAAAA7);
    fault_run(2, 33, 32'd0, 32'hAAAAAAAA);
    fault_run(3, 34, 32'd1, 32'hAAAAAABB);

    // Reset mid-WRITE_B, then a full passing run
    mode = 0;
    pulse_start();
    repeat (70) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    chk("midrst_busy",  32'(busy),         32'd0);
    chk("midrst_wr_en", 32'(rf_wr_enable), 32'd0);
    chk("midrst_done",  32'(done),         32'd0);
    pulse_start();
    count_busy(-1, n);
    chk("after_rst_len",  32'(n),    32'd128);
    chk("after_rst_pass", 32'(pass), 32'd1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
